pcm_to_i2s: RTL and testbench
=============================

// Module: pcm_to_i2s
// PURPOSE
//  Reverse path of the PCM1702 feed: takes two right-justified, MSB-first, per-channel DAC
//  streams (DATAINL/DATAINR) sharing one latch-enable (LEIN), recovers the parallel samples
//  and re-serialises them as a standard I2S stream (LRCKOUT/DATAOUT). Used to loop DAC-side
//  traffic back into an I2S analyser/recorder. Everything runs on BCK; BCK passes through.
// PARAMETERS
//  IN_BITS    20  sample width carried on DATAINL/DATAINR
//  OUT_BITS   24  I2S word width; input MSB-aligned, LSBs zero-padded; IN_BITS<=OUT_BITS<=SLOT_BITS-1
//  SLOT_BITS  32  BCK per I2S half-frame; expected LEIN period = 2*SLOT_BITS
// PORTS
//  BCK       in   1  bit clock; sole clock, all logic on posedge
//  RST       in   1  synchronous, active-high reset
//  LEIN      in   1  shared latch enable; falling edge marks end of both input words
//  DATAINL   in   1  left-channel serial data, MSB first
//  DATAINR   in   1  right-channel serial data, MSB first
//  LRCKOUT   out  1  I2S word clock; 0 = left slot, 1 = right slot
//  DATAOUT   out  1  I2S data, MSB first, 1-BCK delay after LRCKOUT edge
//  LOCKED    out  1  input framing valid, output carries audio
//  LED1      out  1  ~LOCKED, registered (0 = LED on)
// BEHAVIOUR
//  - Reset: LRCKOUT=0, DATAOUT=0, LOCKED=0, LED1=1, holding regs=0, counters=0, FSM=SEARCH.
//  - Deser: per channel, shift DATAINx into IN_BITS-bit SR every posedge. Latch event E0 = posedge
//    where le_q==1 and LEIN==0 (le_q = LEIN registered). At E0 capture {SR[IN_BITS-2:0],DATAINx};
//    bit sampled at E0 is the LSB. Capture occurs in all FSM states.
//  - Period counter counts BCK edges since last E0; good spacing = exactly 2*SLOT_BITS.
//  - FSM SEARCH: first E0 -> ACQUIRE. ACQUIRE: E0 at good spacing -> LOCKED; E0 at bad spacing ->
//    stay ACQUIRE, restart count; count exceeds 2*SLOT_BITS -> SEARCH. LOCKED: E0 at bad spacing
//    or count exceeds 2*SLOT_BITS -> SEARCH. LOCKED output = (state==LOCKED), registered.
//  - Framer: 6-bit bit_cnt (log2(2*SLOT_BITS)), free-running, wraps at 2*SLOT_BITS-1. Every E0
//    forces bit_cnt to 0 (realign). LRCKOUT <= (bit_cnt>=SLOT_BITS).
//  - Timing from E0 (edges after E0): E0+1 LRCKOUT=0; E0+2..E0+1+OUT_BITS left word MSB..LSB;
//    remaining slot bits 0; E0+SLOT_BITS+1 LRCKOUT=1; E0+SLOT_BITS+2 right MSB. Samples from E0 appear
//    in the frame starting E0+1 (latency 1 frame-start, 2 BCK to first data bit).
//  - Mute: if LOCKED==0 at slot start, entire slot DATAOUT=0; LRCKOUT keeps toggling every
//    SLOT_BITS BCK. Lock change mid-slot takes effect at next slot start (no partial words).
//  - Loss of lock mid-word: current slot completes with muted data only if already muted;
//    otherwise completes unchanged, next slot muted.
//  - E0 arriving simultaneously with bit_cnt wrap: realign wins (bit_cnt=0), no double slot.
//  - RST mid-frame: all outputs to reset values next edge; relock needs 2 good E0s.
// STRUCTURE
//  - Shared include i2s_defs.vh: FSM state localparams (ST_SEARCH, ST_ACQUIRE, ST_LOCKED),
//    default widths, good-period constant.
//  - Sub-module pcm_deser (SR + LSB-inclusive capture on E0), instantiated twice (L/R).
//  - Top holds edge detect, period counter, FSM, framer, output shift register.
// TESTING
//  - RST held 5 BCK -> LRCKOUT=0, DATAOUT=0, LOCKED=0, LED1=1.
//  - Two LEIN periods of 64 BCK, L=0x80001, R=0x7FFFF -> LOCKED=1 after 2nd E0; next frame
//    DATAOUT left = 0x800010 (24b), right = 0x7FFFF0, MSB at E0+2 / E0+34.
//  - Locked, one LEIN period of 63 BCK -> LOCKED=0 at that E0+1, following slots all zero,
//    LRCKOUT still 32/32; relock after two 64-BCK periods.
//  - LEIN stuck high 200 BCK while locked -> LOCKED drops at count 65, FSM SEARCH, DATAOUT=0.
//  - RST asserted at bit_cnt=40 mid right word -> outputs reset next edge, no residual bits.
//  - Full-scale ramp, 16 frames -> captured I2S words equal input samples <<4, zero bit slips.

Source files
------------

// File: rtl/pcm_to_i2s_pkg.sv
// Shared widths, lock-state encoding and frame-length helper for the PCM1702-to-I2S loopback.
// Pure definitions; no logic, no latency, no backpressure.
package pcm_to_i2s_pkg;

    localparam int DEF_IN_BITS   = 20;
    localparam int DEF_OUT_BITS  = 24;
    localparam int DEF_SLOT_BITS = 32;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } lock_state_e;

    // One full I2S frame (left + right slot) equals one LEIN period when locked.
    function automatic int good_period(input int slot_bits);
        return 2 * slot_bits;
    endfunction

endpackage

// File: rtl/pcm_to_i2s_deser.sv
// Right-justified serial-to-parallel for one channel; the bit sampled on the latch edge is the LSB.
// Word valid the edge after the latch event; free-running on the bit clock, no backpressure.
module pcm_to_i2s_deser
    import pcm_to_i2s_pkg::*;
#(
    parameter int IN_BITS = DEF_IN_BITS
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               din_i,
    input  logic               e0_i,
    output logic [IN_BITS-1:0] word_o
);

    logic [IN_BITS-1:0] sr_q, sr_d;
    logic [IN_BITS-1:0] word_q, word_d;

    always_comb begin
        sr_d   = {sr_q[IN_BITS-2:0], din_i};
        word_d = e0_i ? sr_d : word_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q   <= '0;
            word_q <= '0;
        end else begin
            sr_q   <= sr_d;
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/pcm_to_i2s.sv
// Recovers L/R samples from a PCM1702-style LEIN/DATAIN feed and re-serialises them as I2S on BCK.
// Latency: E0 + 1 BCK to frame start, E0 + 2 BCK to left MSB; no backpressure, muted until locked.
module pcm_to_i2s
    import pcm_to_i2s_pkg::*;
#(
    parameter int IN_BITS   = DEF_IN_BITS,
    parameter int OUT_BITS  = DEF_OUT_BITS,
    parameter int SLOT_BITS = DEF_SLOT_BITS
) (
    input  logic BCK,
    input  logic RST,
    input  logic LEIN,
    input  logic DATAINL,
    input  logic DATAINR,
    output logic LRCKOUT,
    output logic DATAOUT,
    output logic LOCKED,
    output logic LED1
);

    localparam int FRAME_BITS = good_period(SLOT_BITS);
    localparam int BW         = $clog2(FRAME_BITS);
    localparam int PW         = BW + 2;

    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] BIT_HALF = BW'(SLOT_BITS);
    localparam logic [PW-1:0] PER_GOOD = PW'(FRAME_BITS);
    localparam logic [PW-1:0] PER_SAT  = '1;

    logic                 le_q;
    logic                 e0;
    logic [IN_BITS-1:0]   word_l, word_r;
    logic [OUT_BITS-1:0]  out_l, out_r;
    logic [SLOT_BITS-1:0] slot_word;
    logic                 slot_start;
    logic                 per_good, per_over;

    logic [PW-1:0]        per_q, per_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 lrck_q, lrck_d;
    logic                 dout_q, dout_d;
    logic [SLOT_BITS-1:0] out_sr_q, out_sr_d;
    lock_state_e          state_q;
    logic                 locked_q;
    logic                 led_q;

    assign e0 = le_q & ~LEIN;

    pcm_to_i2s_deser #(.IN_BITS(IN_BITS)) u_deser_l (
        .clk_i  (BCK),
        .rst_i  (RST),
        .din_i  (DATAINL),
        .e0_i   (e0),
        .word_o (word_l)
    );

    pcm_to_i2s_deser #(.IN_BITS(IN_BITS)) u_deser_r (
        .clk_i  (BCK),
        .rst_i  (RST),
        .din_i  (DATAINR),
        .e0_i   (e0),
        .word_o (word_r)
    );

    always_comb begin
        per_good = (per_q == PER_GOOD);
        per_over = (per_q > PER_GOOD);
        // Counter holds "edges since last E0" so a good E0 sees exactly the frame length.
        if (e0)
            per_d = PW'(1);
        else if (per_q == PER_SAT)
            per_d = per_q;
        else
            per_d = per_q + PW'(1);

        // An E0 landing on the wrap edge simply yields 0 once: realign and wrap coincide.
        bit_cnt_d  = (e0 || (bit_cnt_q == BIT_LAST)) ? '0 : bit_cnt_q + BW'(1);
        lrck_d     = (bit_cnt_q >= BIT_HALF);
        slot_start = (bit_cnt_q == '0) || (bit_cnt_q == BIT_HALF);

        out_l     = OUT_BITS'(word_l) << (OUT_BITS - IN_BITS);
        out_r     = OUT_BITS'(word_r) << (OUT_BITS - IN_BITS);
        slot_word = (bit_cnt_q == '0) ? {out_l, {(SLOT_BITS - OUT_BITS){1'b0}}}
                                      : {out_r, {(SLOT_BITS - OUT_BITS){1'b0}}};

        // Mute is decided once per slot so a lock change never produces a partial word.
        if (slot_start)
            out_sr_d = locked_q ? slot_word : '0;
        else
            out_sr_d = {out_sr_q[SLOT_BITS-2:0], 1'b0};
        dout_d = out_sr_q[SLOT_BITS-1];
    end

    always_ff @(posedge BCK) begin
        if (RST) begin
            le_q      <= 1'b0;
            per_q     <= '0;
            bit_cnt_q <= '0;
            lrck_q    <= 1'b0;
            dout_q    <= 1'b0;
            out_sr_q  <= '0;
        end else begin
            le_q      <= LEIN;
            per_q     <= per_d;
            bit_cnt_q <= bit_cnt_d;
            lrck_q    <= lrck_d;
            dout_q    <= dout_d;
            out_sr_q  <= out_sr_d;
        end
    end

    always_ff @(posedge BCK) begin
        if (RST) begin
            state_q  <= ST_SEARCH;
            locked_q <= 1'b0;
            led_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    if (e0)
                        state_q <= ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (e0 && per_good) begin
                        state_q  <= ST_LOCKED;
                        locked_q <= 1'b1;
                        led_q    <= 1'b0;
                    end else if (!e0 && per_over) begin
                        state_q <= ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    if (e0 ? !per_good : per_over) begin
                        state_q  <= ST_SEARCH;
                        locked_q <= 1'b0;
                        led_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_SEARCH;
                    locked_q <= 1'b0;
                    led_q    <= 1'b1;
                end
            endcase
        end
    end

    assign LRCKOUT = lrck_q;
    assign DATAOUT = dout_q;
    assign LOCKED  = locked_q;
    assign LED1    = led_q;

endmodule

// File: tb/tb_pcm_to_i2s.sv
// Directed bench for pcm_to_i2s: drives right-justified LEIN/DATAIN frames and checks recorded I2S output.
module tb_pcm_to_i2s;

    logic BCK, RST, LEIN, DATAINL, DATAINR;
    logic LRCKOUT, DATAOUT, LOCKED, LED1;

    int n_chk;
    int n_fail;
    int cyc;
    int last_e0;

    logic lr_h  [0:4095];
    logic do_h  [0:4095];
    logic lk_h  [0:4095];
    logic led_h [0:4095];

    pcm_to_i2s dut (
        .BCK     (BCK),
        .RST     (RST),
        .LEIN    (LEIN),
        .DATAINL (DATAINL),
        .DATAINR (DATAINR),
        .LRCKOUT (LRCKOUT),
        .DATAOUT (DATAOUT),
        .LOCKED  (LOCKED),
        .LED1    (LED1)
    );

    initial begin
        BCK = 1'b0;
        forever #5 BCK = ~BCK;
    end

    // Drive inputs for the next edge, then record outputs 1 time unit after that edge.
    task automatic tick(input logic le, input logic dl, input logic dr);
        LEIN    = le;
        DATAINL = dl;
        DATAINR = dr;
        @(posedge BCK);
        #1;
        cyc = cyc + 1;
        lr_h[cyc]  = LRCKOUT;
        do_h[cyc]  = DATAOUT;
        lk_h[cyc]  = LOCKED;
        led_h[cyc] = LED1;
    endtask

    // Right-justified frame: LSB sampled on the last edge, where LEIN has just fallen.
    task automatic send_frame(input logic [19:0] l, input logic [19:0] r, input int period,
                              output int e0_edge);
        for (int k = 0; k < period; k++) begin
            logic [19:0] tl, tr;
            tl = l >> (period - 1 - k);
            tr = r >> (period - 1 - k);
            tick(k != period - 1, tl[0], tr[0]);
        end
        e0_edge = cyc;
        last_e0 = cyc;
    endtask

    function automatic logic [31:0] get_bits(input int s);
        logic [31:0] v;
        v = '0;
        for (int b = 0; b < 32; b++) v = {v[30:0], do_h[s + b]};
        return v;
    endfunction

    task automatic test_reset;
        RST = 1'b1;
        repeat (5) tick(1'b0, 1'b0, 1'b0);
        n_chk++; if (LRCKOUT !== 1'b0) begin n_fail++; $display("FAIL reset_lrck: got %b expected 0", LRCKOUT); end
        n_chk++; if (DATAOUT !== 1'b0) begin n_fail++; $display("FAIL reset_dout: got %b expected 0", DATAOUT); end
        n_chk++; if (LOCKED !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", LOCKED); end
        n_chk++; if (LED1 !== 1'b1) begin n_fail++; $display("FAIL reset_led: got %b expected 1", LED1); end
        RST = 1'b0;
    endtask

    task automatic test_lock;
        int e1, e2, e3, e4;
        send_frame(20'h80001, 20'h7FFFF, 64, e1);
        send_frame(20'h80001, 20'h7FFFF, 64, e2);
        send_frame(20'h80001, 20'h7FFFF, 64, e3);
        send_frame(20'h80001, 20'h7FFFF, 64, e4);
        n_chk++; if (lk_h[e1] !== 1'b0) begin n_fail++; $display("FAIL lock_first_e0: got %b expected 0", lk_h[e1]); end
        n_chk++; if (lk_h[e2] !== 1'b1) begin n_fail++; $display("FAIL lock_second_e0: got %b expected 1", lk_h[e2]); end
        n_chk++; if (led_h[e2] !== 1'b0) begin n_fail++; $display("FAIL lock_led: got %b expected 0", led_h[e2]); end
        n_chk++; if (get_bits(e1 + 2) !== 32'h0) begin n_fail++; $display("FAIL lock_acquire_muted: got %h expected 00000000", get_bits(e1 + 2)); end
        n_chk++; if (get_bits(e2 + 2) !== 32'h80001000) begin n_fail++; $display("FAIL lock_left_word: got %h expected 80001000", get_bits(e2 + 2)); end
        n_chk++; if (get_bits(e2 + 34) !== 32'h7FFFF000) begin n_fail++; $display("FAIL lock_right_word: got %h expected 7ffff000", get_bits(e2 + 34)); end
        n_chk++; if (lr_h[e2 + 1] !== 1'b0) begin n_fail++; $display("FAIL lock_lrck_e0p1: got %b expected 0", lr_h[e2 + 1]); end
        n_chk++; if (lr_h[e2 + 32] !== 1'b0) begin n_fail++; $display("FAIL lock_lrck_e0p32: got %b expected 0", lr_h[e2 + 32]); end
        n_chk++; if (lr_h[e2 + 33] !== 1'b1) begin n_fail++; $display("FAIL lock_lrck_e0p33: got %b expected 1", lr_h[e2 + 33]); end
        n_chk++; if (lr_h[e2 + 64] !== 1'b1) begin n_fail++; $display("FAIL lock_lrck_e0p64: got %b expected 1", lr_h[e2 + 64]); end
        n_chk++; if (lk_h[e4] !== 1'b1) begin n_fail++; $display("FAIL lock_hold: got %b expected 1", lk_h[e4]); end
    endtask

    task automatic test_bad_period;
        int eb, ea1, ea2, ea3;
        send_frame(20'h12345, 20'hABCDE, 63, eb);
        send_frame(20'h12345, 20'hABCDE, 64, ea1);
        send_frame(20'h12345, 20'hABCDE, 64, ea2);
        send_frame(20'h12345, 20'hABCDE, 64, ea3);
        n_chk++; if (lk_h[eb - 1] !== 1'b1) begin n_fail++; $display("FAIL bad_before: got %b expected 1", lk_h[eb - 1]); end
        n_chk++; if (lk_h[eb + 1] !== 1'b0) begin n_fail++; $display("FAIL bad_unlock: got %b expected 0", lk_h[eb + 1]); end
        n_chk++; if (led_h[eb + 1] !== 1'b1) begin n_fail++; $display("FAIL bad_led: got %b expected 1", led_h[eb + 1]); end
        n_chk++; if (get_bits(eb + 2) !== 32'h0) begin n_fail++; $display("FAIL bad_left_muted: got %h expected 00000000", get_bits(eb + 2)); end
        n_chk++; if (get_bits(eb + 34) !== 32'h0) begin n_fail++; $display("FAIL bad_right_muted: got %h expected 00000000", get_bits(eb + 34)); end
        n_chk++; if (lr_h[eb + 32] !== 1'b0) begin n_fail++; $display("FAIL bad_lrck_low: got %b expected 0", lr_h[eb + 32]); end
        n_chk++; if (lr_h[eb + 33] !== 1'b1) begin n_fail++; $display("FAIL bad_lrck_high: got %b expected 1", lr_h[eb + 33]); end
        n_chk++; if (lk_h[ea1] !== 1'b0) begin n_fail++; $display("FAIL relock_first: got %b expected 0", lk_h[ea1]); end
        n_chk++; if (get_bits(ea1 + 2) !== 32'h0) begin n_fail++; $display("FAIL relock_acq_muted: got %h expected 00000000", get_bits(ea1 + 2)); end
        n_chk++; if (lk_h[ea2] !== 1'b1) begin n_fail++; $display("FAIL relock_second: got %b expected 1", lk_h[ea2]); end
        n_chk++; if (get_bits(ea2 + 2) !== 32'h12345000) begin n_fail++; $display("FAIL relock_left: got %h expected 12345000", get_bits(ea2 + 2)); end
        n_chk++; if (get_bits(ea2 + 34) !== 32'hABCDE000) begin n_fail++; $display("FAIL relock_right: got %h expected abcde000", get_bits(ea2 + 34)); end
    endtask

    task automatic test_stuck_high;
        int s;
        logic any_one;
        s = last_e0;
        repeat (200) tick(1'b1, 1'b0, 1'b0);
        any_one = 1'b0;
        for (int b = s + 98; b <= s + 200; b++) any_one = any_one | do_h[b];
        n_chk++; if (lk_h[s + 64] !== 1'b1) begin n_fail++; $display("FAIL stuck_count64: got %b expected 1", lk_h[s + 64]); end
        n_chk++; if (lk_h[s + 65] !== 1'b0) begin n_fail++; $display("FAIL stuck_count65: got %b expected 0", lk_h[s + 65]); end
        n_chk++; if (led_h[s + 65] !== 1'b1) begin n_fail++; $display("FAIL stuck_led: got %b expected 1", led_h[s + 65]); end
        n_chk++; if (any_one !== 1'b0) begin n_fail++; $display("FAIL stuck_dout_muted: got %b expected 0", any_one); end
        n_chk++; if (lr_h[s + 129] !== 1'b0) begin n_fail++; $display("FAIL stuck_lrck_low: got %b expected 0", lr_h[s + 129]); end
        n_chk++; if (lr_h[s + 161] !== 1'b1) begin n_fail++; $display("FAIL stuck_lrck_high: got %b expected 1", lr_h[s + 161]); end
        n_chk++; if (lk_h[s + 200] !== 1'b0) begin n_fail++; $display("FAIL stuck_end: got %b expected 0", lk_h[s + 200]); end
    endtask

    task automatic test_reset_mid;
        int r1, r2, r3, rs;
        logic any_one;
        send_frame(20'hFFFFF, 20'hFFFFF, 64, r1);
        send_frame(20'hFFFFF, 20'hFFFFF, 64, r2);
        send_frame(20'hFFFFF, 20'hFFFFF, 64, r3);
        repeat (40) tick(1'b1, 1'b0, 1'b0);
        n_chk++; if (lk_h[r3] !== 1'b1) begin n_fail++; $display("FAIL rmid_locked: got %b expected 1", lk_h[r3]); end
        n_chk++; if (do_h[r3 + 40] !== 1'b1) begin n_fail++; $display("FAIL rmid_in_word: got %b expected 1", do_h[r3 + 40]); end
        n_chk++; if (lr_h[r3 + 40] !== 1'b1) begin n_fail++; $display("FAIL rmid_right_slot: got %b expected 1", lr_h[r3 + 40]); end
        RST = 1'b1;
        tick(1'b1, 1'b0, 1'b0);
        n_chk++; if (LRCKOUT !== 1'b0) begin n_fail++; $display("FAIL rmid_lrck: got %b expected 0", LRCKOUT); end
        n_chk++; if (DATAOUT !== 1'b0) begin n_fail++; $display("FAIL rmid_dout: got %b expected 0", DATAOUT); end
        n_chk++; if (LOCKED !== 1'b0) begin n_fail++; $display("FAIL rmid_locked_clr: got %b expected 0", LOCKED); end
        n_chk++; if (LED1 !== 1'b1) begin n_fail++; $display("FAIL rmid_led: got %b expected 1", LED1); end
        tick(1'b1, 1'b0, 1'b0);
        RST = 1'b0;
        rs = cyc;
        repeat (40) tick(1'b1, 1'b0, 1'b0);
        any_one = 1'b0;
        for (int b = rs; b <= cyc; b++) any_one = any_one | do_h[b];
        n_chk++; if (any_one !== 1'b0) begin n_fail++; $display("FAIL rmid_residual: got %b expected 0", any_one); end
    endtask

    task automatic test_ramp;
        int p;
        int dummy;
        int e_r [16];
        logic [19:0] li;
        send_frame(20'h0, 20'h0, 64, p);
        for (int i = 0; i < 16; i++) begin
            li = 20'(32'h11111 * i);
            send_frame(li, ~li, 64, e_r[i]);
        end
        send_frame(20'h0, 20'h0, 64, dummy);
        tick(1'b1, 1'b0, 1'b0);
        n_chk++; if (lk_h[e_r[0]] !== 1'b1) begin n_fail++; $display("FAIL ramp_locked: got %b expected 1", lk_h[e_r[0]]); end
        for (int i = 0; i < 16; i++) begin
            li = 20'(32'h11111 * i);
            n_chk++;
            if (get_bits(e_r[i] + 2) !== {li, 12'h0}) begin
                n_fail++; $display("FAIL ramp_left[%0d]: got %h expected %h", i, get_bits(e_r[i] + 2), {li, 12'h0});
            end
            n_chk++;
            if (get_bits(e_r[i] + 34) !== {~li, 12'h0}) begin
                n_fail++; $display("FAIL ramp_right[%0d]: got %h expected %h", i, get_bits(e_r[i] + 34), {~li, 12'h0});
            end
        end
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        cyc     = 0;
        last_e0 = 0;
        RST     = 1'b1;
        LEIN    = 1'b0;
        DATAINL = 1'b0;
        DATAINR = 1'b0;
        test_reset();
        test_lock();
        test_bad_period();
        test_stuck_high();
        test_reset_mid();
        test_ramp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
